// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, read-channel states and the strobe-width helper.
package axi_lite_pkg;

  localparam int unsigned RESP_WIDTH = 3;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 3'd0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 3'd2;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Bus strobe ports carry one spare MSB above the byte lanes.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8 + 1;
  endfunction

endpackage

// File: rtl/axi_lite_reg_decode.sv
// Address decoder for the register bank: maps a byte address to a hit flag and register index.
module axi_lite_reg_decode #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_hit,
  output logic [IDX_W-1:0]      o_idx
);

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_word;

  // Offset wraps in ADDR_WIDTH bits; the lower-bound compare rejects wrapped values.
  assign w_offset = i_addr - ADDR_WIDTH'(BASE_ADDR);
  assign w_word   = w_offset >> 2;

  assign o_hit = (i_addr >= ADDR_WIDTH'(BASE_ADDR))
              && (i_addr[1:0] == 2'b00)
              && (32'(w_word) < NUM_REGS);

  assign o_idx = w_word[IDX_W-1:0];

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder with a bank of word-wide read/write registers, exported flat on reg_q.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = axi_lite_pkg::RESP_WIDTH,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [strb_width(DATA_WIDTH)-1:0] s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [RESP_WIDTH-1:0]          s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int unsigned STRB_W = strb_width(DATA_WIDTH);
  localparam int unsigned LANES  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [RESP_WIDTH-1:0] L_OKAY   = RESP_WIDTH'(RESP_OKAY);
  localparam logic [RESP_WIDTH-1:0] L_SLVERR = RESP_WIDTH'(RESP_SLVERR);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [LANES-1:0]      r_wstrb;
  logic                  r_bvalid;
  logic [RESP_WIDTH-1:0] r_bresp;

  rd_state_e             r_rd_state;
  rd_state_e             w_rd_state_nxt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [RESP_WIDTH-1:0] r_rresp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_commit;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_arready;
  logic                  w_rvalid;
  logic                  w_rd_load;

  logic                  w_wr_hit;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_rd_hit;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0] w_wmask;
  logic                  w_unused_strb_msb;

  assign w_unused_strb_msb = s_axi_wstrb[STRB_W-1];

  axi_lite_reg_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_wr_decode (
    .i_addr (r_awaddr),
    .o_hit  (w_wr_hit),
    .o_idx  (w_wr_idx)
  );

  axi_lite_reg_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_rd_decode (
    .i_addr (s_axi_araddr),
    .o_hit  (w_rd_hit),
    .o_idx  (w_rd_idx)
  );

  // ---------------------------------------------------------------- write path
  assign s_axi_awready = ~r_aw_held & ~r_bvalid;
  assign s_axi_wready  = ~r_w_held & ~r_bvalid;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;

  assign w_aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_w_hs   = s_axi_wvalid & s_axi_wready;
  assign w_b_hs   = r_bvalid & s_axi_bready;
  assign w_commit = r_aw_held & r_w_held & ~r_bvalid;

  for (genvar b = 0; b < LANES; b++) begin : g_wmask
    assign w_wmask[8*b +: 8] = {8{r_wstrb[b]}};
  end

  // AW/W latches and the B response; held flags clear only on the B handshake.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin : p_wr_ctrl
    if (!s_axi_aresetn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb[LANES-1:0];
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_hit ? L_OKAY : L_SLVERR;
      end else if (w_b_hs) begin
        r_bvalid  <= 1'b0;
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  // Register bank; a zero strobe mask leaves the target word untouched.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin : p_bank
    if (!s_axi_aresetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[IDX_W'(i)] <= '0;
      end
    end else if (w_commit && w_wr_hit) begin
      r_regs[w_wr_idx] <= (r_regs[w_wr_idx] & ~w_wmask) | (r_wdata & w_wmask);
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end

  // ----------------------------------------------------------------- read path
  assign w_ar_hs = s_axi_arvalid & w_arready;
  assign w_r_hs  = w_rvalid & s_axi_rready;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin : p_rd_state
    if (!s_axi_aresetn) begin
      r_rd_state <= R_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
    end
  end

  always_comb begin : p_rd_next
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_DATA;
      R_DATA:  if (w_r_hs)  w_rd_state_nxt = R_IDLE;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin : p_rd_out
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    w_rd_load = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        w_arready = 1'b1;
        w_rd_load = s_axi_arvalid;
      end
      R_DATA:  w_rvalid = 1'b1;
      default: ;
    endcase
  end

  // Capture samples the bank before any same-edge write lands.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin : p_rd_data
    if (!s_axi_aresetn) begin
      r_rdata <= '0;
      r_rresp <= '0;
    end else if (w_rd_load) begin
      r_rdata <= w_rd_hit ? r_regs[w_rd_idx] : '0;
      r_rresp <= w_rd_hit ? L_OKAY : L_SLVERR;
    end
  end

  assign s_axi_arready = w_arready;
  assign s_axi_rvalid  = w_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: two instances (base 0 and base 16), directed vectors plus a
// transaction-level model checked every cycle.
module tb_axi_lite_reg_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned RW = 3;
  localparam int unsigned NR = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0]    awaddr  [2];
  logic             awvalid [2];
  logic             awready [2];
  logic [DW-1:0]    wdata   [2];
  logic [4:0]       wstrb   [2];
  logic             wvalid  [2];
  logic             wready  [2];
  logic [RW-1:0]    bresp   [2];
  logic             bvalid  [2];
  logic             bready  [2];
  logic [AW-1:0]    araddr  [2];
  logic             arvalid [2];
  logic             arready [2];
  logic [DW-1:0]    rdata   [2];
  logic [RW-1:0]    rresp   [2];
  logic             rvalid  [2];
  logic             rready  [2];
  logic [NR*DW-1:0] regq    [2];

  int n_total = 0;
  int n_pass  = 0;

  axi_lite_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .NUM_REGS(NR), .BASE_ADDR(0)) u_m1 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr[0]), .s_axi_awvalid(awvalid[0]), .s_axi_awready(awready[0]),
    .s_axi_wdata(wdata[0]), .s_axi_wstrb(wstrb[0]), .s_axi_wvalid(wvalid[0]), .s_axi_wready(wready[0]),
    .s_axi_bresp(bresp[0]), .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready[0]),
    .s_axi_araddr(araddr[0]), .s_axi_arvalid(arvalid[0]), .s_axi_arready(arready[0]),
    .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]), .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready[0]),
    .reg_q(regq[0])
  );

  axi_lite_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .NUM_REGS(NR), .BASE_ADDR(16)) u_m2 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr[1]), .s_axi_awvalid(awvalid[1]), .s_axi_awready(awready[1]),
    .s_axi_wdata(wdata[1]), .s_axi_wstrb(wstrb[1]), .s_axi_wvalid(wvalid[1]), .s_axi_wready(wready[1]),
    .s_axi_bresp(bresp[1]), .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready[1]),
    .s_axi_araddr(araddr[1]), .s_axi_arvalid(arvalid[1]), .s_axi_arready(arready[1]),
    .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]), .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready[1]),
    .reg_q(regq[1])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------------ model
  logic [DW-1:0] m_regs  [2][NR];
  int unsigned   m_base  [2] = '{0, 16};
  bit            aw_busy [2];
  bit            w_busy  [2];
  bit            r_busy  [2];
  bit            b_seen  [2];
  bit            r_seen  [2];
  int            b_wait  [2];
  logic [AW-1:0] m_awaddr[2];
  logic [DW-1:0] m_wdata [2];
  logic [3:0]    m_wstrb [2];
  logic [RW-1:0] m_bresp [2];
  logic [DW-1:0] m_rdata [2];
  logic [RW-1:0] m_rresp [2];

  function automatic bit f_hit(input int unsigned a, input int unsigned base);
    return (a >= base) && (a % 4 == 0) && ((a - base) / 4 < NR);
  endfunction

  function automatic logic [NR*DW-1:0] model_q(input bit d);
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[d][i];
    return v;
  endfunction

  task automatic mon(input bit d);
    int unsigned a;
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_regs[d][i] = '0;
      aw_busy[d] = 0; w_busy[d] = 0; r_busy[d] = 0;
      b_seen[d] = 0; r_seen[d] = 0; b_wait[d] = 0;
      chk("rst_regq", 128'(regq[d]), 128'(0));
      chk("rst_valids", 128'({bvalid[d], rvalid[d]}), 128'(0));
      return;
    end
    // write response: apply the held transaction when B first appears
    if (bvalid[d] && !b_seen[d]) begin
      chk("b_req", 128'({aw_busy[d], w_busy[d]}), 128'(2'b11));
      a = int'(m_awaddr[d]);
      if (f_hit(a, m_base[d])) begin
        m_bresp[d] = 3'd0;
        for (int b = 0; b < 4; b++)
          if (m_wstrb[d][b]) m_regs[d][(a - m_base[d]) / 4][8*b +: 8] = m_wdata[d][8*b +: 8];
      end else begin
        m_bresp[d] = 3'd2;
      end
      b_seen[d] = 1;
    end
    if (bvalid[d]) chk("bresp", 128'(bresp[d]), 128'(m_bresp[d]));
    else if (aw_busy[d] && w_busy[d]) begin
      b_wait[d]++;
      chk("b_latency", 128'(b_wait[d] <= 1), 128'(1));
    end
    chk("regq", 128'(regq[d]), 128'(model_q(d)));
    chk("awready", 128'(awready[d]), 128'(!aw_busy[d]));
    chk("wready", 128'(wready[d]), 128'(!w_busy[d]));
    chk("arready", 128'(arready[d]), 128'(!r_busy[d]));
    if (rvalid[d]) begin
      if (!r_seen[d]) begin
        chk("r_req", 128'(r_busy[d]), 128'(1));
        r_seen[d] = 1;
      end
      chk("rdata", 128'(rdata[d]), 128'(m_rdata[d]));
      chk("rresp", 128'(rresp[d]), 128'(m_rresp[d]));
    end else if (r_busy[d]) begin
      chk("r_latency", 128'(rvalid[d]), 128'(1));
    end
    // handshakes that complete on the coming edge
    if (bvalid[d] && bready[d]) begin
      aw_busy[d] = 0; w_busy[d] = 0; b_seen[d] = 0; b_wait[d] = 0;
    end
    if (rvalid[d] && rready[d]) begin
      r_busy[d] = 0; r_seen[d] = 0;
    end
    if (awvalid[d] && awready[d]) begin
      aw_busy[d] = 1; m_awaddr[d] = awaddr[d];
    end
    if (wvalid[d] && wready[d]) begin
      w_busy[d] = 1; m_wdata[d] = wdata[d]; m_wstrb[d] = wstrb[d][3:0];
    end
    if (arvalid[d] && arready[d]) begin
      a = int'(araddr[d]);
      r_busy[d] = 1;
      m_rdata[d] = f_hit(a, m_base[d]) ? m_regs[d][(a - m_base[d]) / 4] : '0;
      m_rresp[d] = f_hit(a, m_base[d]) ? 3'd0 : 3'd2;
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
  end

  // --------------------------------------------------------------- drivers
  function automatic logic rdy(input bit d, input int ch);
    return (ch == 0) ? awready[d] : (ch == 1) ? wready[d] : arready[d];
  endfunction

  // ch: 0 = AW, 1 = W, 2 = AR; returns just after the handshake edge
  task automatic do_req(input bit d, input int ch, input logic [AW-1:0] a,
                        input logic [DW-1:0] v, input logic [3:0] s);
    int n = 0;
    case (ch)
      0:       begin awaddr[d] = a; awvalid[d] = 1'b1; end
      1:       begin wdata[d] = v; wstrb[d] = {1'b1, s}; wvalid[d] = 1'b1; end
      default: begin araddr[d] = a; arvalid[d] = 1'b1; end
    endcase
    @(negedge clk);
    while (!rdy(d, ch) && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("req_timeout", 128'(rdy(d, ch)), 128'(1));
    @(posedge clk); #1;
    case (ch)
      0:       awvalid[d] = 1'b0;
      1:       wvalid[d]  = 1'b0;
      default: arvalid[d] = 1'b0;
    endcase
  endtask

  task automatic wr(input bit d, input logic [AW-1:0] a, input logic [DW-1:0] v, input logic [3:0] s);
    fork
      do_req(d, 0, a, '0, s);
      do_req(d, 1, a, v, s);
    join
  endtask

  task automatic wait_b(input bit d);
    int n = 0;
    @(negedge clk);
    while (bvalid[d] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("b_timeout", 128'(bvalid[d]), 128'(1));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; awvalid[i] = 1'b0; wdata[i] = '0; wstrb[i] = '0; wvalid[i] = 1'b0;
      araddr[i] = '0; arvalid[i] = 1'b0; bready[i] = 1'b1; rready[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    step();

    @(negedge clk);
    chk("rst_awready", 128'(awready[0]), 128'(1));
    chk("rst_wready", 128'(wready[0]), 128'(1));
    chk("rst_arready", 128'(arready[0]), 128'(1));
    chk("rst_reg_q", 128'(regq[0]), 128'(0));
    step();

    // T1: AW and W together
    wr(1'b0, 8'h00, 32'h17, 4'hF);
    @(negedge clk); chk("t1_b_not_yet", 128'(bvalid[0]), 128'(0));
    @(negedge clk);
    chk("t1_bvalid", 128'(bvalid[0]), 128'(1));
    chk("t1_bresp", 128'(bresp[0]), 128'(0));
    chk("t1_reg0", 128'(regq[0][31:0]), 128'(32'h17));
    step();

    // T2: W three cycles ahead of AW, sparse strobe
    do_req(1'b0, 1, 8'h00, 32'hAABBCCDD, 4'h5);
    repeat (3) begin @(negedge clk); chk("t2_wready_wait", 128'(wready[0]), 128'(0)); end
    step();
    do_req(1'b0, 0, 8'h04, '0, 4'h0);
    wait_b(1'b0);
    chk("t2_bresp", 128'(bresp[0]), 128'(0));
    chk("t2_reg1", 128'(regq[0][63:32]), 128'(32'h00BB00DD));
    step();

    // T3: read with rready stalled
    rready[0] = 1'b0;
    do_req(1'b0, 2, 8'h04, '0, 4'h0);
    repeat (4) begin
      @(negedge clk);
      chk("t3_rvalid", 128'(rvalid[0]), 128'(1));
      chk("t3_rdata", 128'(rdata[0]), 128'(32'h00BB00DD));
      chk("t3_arready", 128'(arready[0]), 128'(0));
    end
    step();
    rready[0] = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t3_rvalid_drop", 128'(rvalid[0]), 128'(0));
    chk("t3_arready_back", 128'(arready[0]), 128'(1));
    step();

    // T4: out-of-range read and misaligned write
    fork
      do_req(1'b0, 2, 8'h10, '0, 4'h0);
      wr(1'b0, 8'h02, 32'hDEADBEEF, 4'hF);
    join
    @(negedge clk);
    chk("t4_rvalid", 128'(rvalid[0]), 128'(1));
    chk("t4_rresp", 128'(rresp[0]), 128'(2));
    chk("t4_rdata", 128'(rdata[0]), 128'(0));
    @(negedge clk);
    chk("t4_bvalid", 128'(bvalid[0]), 128'(1));
    chk("t4_bresp", 128'(bresp[0]), 128'(2));
    chk("t4_regs", 128'(regq[0]), {32'h0, 32'h0, 32'h00BB00DD, 32'h17});
    step();

    // T5: base 16, write commit and read capture on the same edge
    fork
      wr(1'b1, 8'h14, 32'h25, 4'hF);
      begin step(); do_req(1'b1, 2, 8'h14, '0, 4'h0); end
    join
    @(negedge clk);
    chk("t5_rvalid", 128'(rvalid[1]), 128'(1));
    chk("t5_rdata_old", 128'(rdata[1]), 128'(0));
    chk("t5_bvalid", 128'(bvalid[1]), 128'(1));
    chk("t5_bresp", 128'(bresp[1]), 128'(0));
    chk("t5_reg1", 128'(regq[1][63:32]), 128'(32'h25));
    step();
    do_req(1'b1, 2, 8'h14, '0, 4'h0);
    @(negedge clk);
    chk("t5_rdata_new", 128'(rdata[1]), 128'(32'h25));
    chk("t5_rresp_new", 128'(rresp[1]), 128'(0));
    step();

    // T6: reset while both responses are pending
    bready[0] = 1'b0;
    rready[0] = 1'b0;
    fork
      wr(1'b0, 8'h08, 32'h11223344, 4'hF);
      do_req(1'b0, 2, 8'h00, '0, 4'h0);
    join
    @(negedge clk);
    @(negedge clk);
    chk("t6_both_pending", 128'({bvalid[0], rvalid[0]}), 128'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_bvalid_drop", 128'(bvalid[0]), 128'(0));
    chk("t6_rvalid_drop", 128'(rvalid[0]), 128'(0));
    chk("t6_regq0_clear", 128'(regq[0]), 128'(0));
    chk("t6_regq1_clear", 128'(regq[1]), 128'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    bready[0] = 1'b1;
    rready[0] = 1'b1;
    step();
    wr(1'b0, 8'h0C, 32'hCAFEF00D, 4'hF);
    wait_b(1'b0);
    chk("t6_bresp", 128'(bresp[0]), 128'(0));
    chk("t6_reg3", 128'(regq[0][127:96]), 128'(32'hCAFEF00D));
    step();
    do_req(1'b0, 2, 8'h0C, '0, 4'h0);
    @(negedge clk);
    chk("t6_rdata", 128'(rdata[0]), 128'(32'hCAFEF00D));
    chk("t6_rresp", 128'(rresp[0]), 128'(0));
    step();
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
